// File: rtl/clk_div_pkg.sv
// Shared definitions for the programmable clock divider.
//   DIV_W_DEF    default divisor width
//   DIV_INIT_DEF default divisor after reset
//   div_t        divisor type at the default width
//   hi_cnt()     number of clk_in cycles clk_q stays high per period, ceil(N/2)
package clk_div_pkg;

  localparam int unsigned DIV_W_DEF    = 8;
  localparam int unsigned DIV_INIT_DEF = 2;

  typedef logic [DIV_W_DEF-1:0] div_t;

  // Written as (N>>1)+N[0] so it never needs a wider intermediate than N itself.
  function automatic logic [31:0] hi_cnt(input logic [31:0] n);
    return (n >> 1) + {31'd0, n[0]};
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Counter/waveform engine of the programmable divider.
// Counts 0..N-1 on clk_i while enabled and produces a registered divided clock and a
// one-cycle tick at the start of each period. Optional macro CLK_DIV_ODD50_EN adds a
// negedge retiming flop that trims odd-N high phases to an exact 50% duty.
// Ports:
//   clk_i   clock (posedge; negedge also used when CLK_DIV_ODD50_EN is defined)
//   rst_ni  synchronous active-low reset
//   en_i    1 = count, 0 = hold counter and clock level
//   div_i   divisor in effect, never 0
//   wrap_o  counter is at N-1 and enabled: next edge starts a new period
//   clk_o   divided clock (before the N=1 bypass mux in the top)
//   tick_o  registered one-cycle pulse at the start of each period
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W = DIV_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             wrap_o,
  output logic             clk_o,
  output logic             tick_o
);

  logic [DIV_W-1:0] cnt_q, cnt_d, cnt_nxt, hi;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic             last;

  assign hi      = DIV_W'(hi_cnt(32'(div_i)));
  assign last    = (cnt_q == div_i - 1'b1);
  assign cnt_nxt = last ? '0 : cnt_q + 1'b1;
  assign wrap_o  = en_i & last;

  always_comb begin
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    tick_d = 1'b0;
    if (en_i) begin
      cnt_d  = cnt_nxt;
      // At a wrap cnt_nxt is 0, so clk_q rises regardless of a divisor change.
      clk_d  = (cnt_nxt < hi);
      tick_d = (cnt_nxt == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      clk_q  <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

`ifdef CLK_DIV_ODD50_EN
  // Half-cycle delayed copy; ANDing delays the rise by half a clk_in period.
  logic clk_qn_q;

  always_ff @(negedge clk_i) begin
    if (!rst_ni) begin
      clk_qn_q <= 1'b1;
    end else begin
      clk_qn_q <= clk_q;
    end
  end

  assign clk_o = (div_i[0] && (div_i != DIV_W'(1))) ? (clk_q & clk_qn_q) : clk_q;
`else
  assign clk_o = clk_q;
`endif

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider (divisor 1..2^DIV_W-1).
// A new divisor is taken over a valid/ready handshake into a pending register and
// applied only at a period boundary, so clk_out never produces a runt pulse.
// Optional macro CLK_DIV_ODD50_EN: exact 50% duty for odd divisors (see clk_div_core).
// Ports:
//   clk_in     sole clock
//   rst_n      synchronous active-low reset
//   en         1 = run, 0 = freeze counter and clk_out level
//   div_in     requested divisor (0 is taken as 1)
//   div_valid  div_in valid
//   div_ready  a new divisor can be accepted
//   clk_out    divided clock (clk_in itself when the divisor is 1)
//   tick       one-cycle clk_in pulse at the start of each clk_out period
//   div_cur    divisor currently in effect
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int unsigned DIV_W    = DIV_W_DEF,
  parameter int unsigned DIV_INIT = DIV_INIT_DEF
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] div_in,
  input  logic             div_valid,
  output logic             div_ready,
  output logic             clk_out,
  output logic             tick,
  output logic [DIV_W-1:0] div_cur
);

  logic [DIV_W-1:0] div_cur_q, div_cur_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_v_q, pend_v_d;
  logic             accept, wrap, core_clk;

  assign accept = div_valid & ~pend_v_q;

  always_comb begin
    div_cur_d = div_cur_q;
    pend_d    = pend_q;
    pend_v_d  = pend_v_q;
    // Uses the registered pend_v, so a value accepted at a wrap waits for the next wrap.
    if (wrap && pend_v_q) begin
      div_cur_d = pend_q;
      pend_v_d  = 1'b0;
    end
    if (accept) begin
      pend_d   = (div_in == '0) ? DIV_W'(1) : div_in;
      pend_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      div_cur_q <= DIV_W'(DIV_INIT);
      pend_q    <= '0;
      pend_v_q  <= 1'b0;
    end else begin
      div_cur_q <= div_cur_d;
      pend_q    <= pend_d;
      pend_v_q  <= pend_v_d;
    end
  end

  clk_div_core #(
    .DIV_W (DIV_W)
  ) u_core (
    .clk_i  (clk_in),
    .rst_ni (rst_n),
    .en_i   (en),
    .div_i  (div_cur_q),
    .wrap_o (wrap),
    .clk_o  (core_clk),
    .tick_o (tick)
  );

  // Divide-by-1 cannot be made from registered logic; pass the input clock through.
  assign clk_out   = (div_cur_q == DIV_W'(1)) ? clk_in : core_clk;
  assign div_ready = ~pend_v_q;
  assign div_cur   = div_cur_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog (DIV_W=8, DIV_INIT=2).
// Each test pushes the expected per-cycle {clk_out, tick, div_cur, div_ready} into a
// scoreboard, then drives its stimulus cycle by cycle and pops/compares one entry per
// clk_in cycle, sampled 1 time unit after the rising edge.
module tb_clk_div_prog;

  typedef struct packed {
    logic       clk;
    logic       tick;
    logic [7:0] cur;
    logic       rdy;
  } obs_t;

  logic       clk_in = 1'b0;
  logic       rst_n, en, div_valid, div_ready, clk_out, tick;
  logic [7:0] div_in, div_cur;

  obs_t sb[$];
  obs_t e, got;
  int   total = 0;
  int   bad   = 0;

  always #5 clk_in = ~clk_in;

  clk_div_prog #(
    .DIV_W    (8),
    .DIV_INIT (2)
  ) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .en        (en),
    .div_in    (div_in),
    .div_valid (div_valid),
    .div_ready (div_ready),
    .clk_out   (clk_out),
    .tick      (tick),
    .div_cur   (div_cur)
  );

  // Expected clk_out level p cycles into a period of N, sampled just after posedge.
  function automatic logic exp_lvl(int n, int p);
    int hi;
    hi = (n + 1) / 2;
    if (n == 1) return 1'b1;
`ifdef CLK_DIV_ODD50_EN
    if (n % 2 == 1) return (p >= 1) && (p < hi);
`endif
    return p < hi;
  endfunction

  task automatic push_range(int n, int pf, int pt, logic rdy);
    for (int p = pf; p <= pt; p++) begin
      sb.push_back('{clk: exp_lvl(n, p), tick: (p == 0), cur: 8'(n), rdy: rdy});
    end
  endtask

  task automatic push_one(logic c, logic t, int cur, logic r);
    sb.push_back('{clk: c, tick: t, cur: 8'(cur), rdy: r});
  endtask

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    push_one(1'b1, 1'b0, 2, 1'b1);
    push_one(1'b1, 1'b0, 2, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      cyc();
      got = '{clk: clk_out, tick: tick, cur: div_cur, rdy: div_ready};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset cyc %0d: got clk=%b tick=%b cur=%0d rdy=%b want clk=%b tick=%b cur=%0d rdy=%b",
                 i, got.clk, got.tick, got.cur, got.rdy, e.clk, e.tick, e.cur, e.rdy);
      end
    end
  endtask

  task automatic test_div2();
    push_range(2, 1, 1, 1'b1);
    repeat (3) push_range(2, 0, 1, 1'b1);
    push_range(2, 0, 0, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) rst_n = 1'b1;
      cyc();
      got = '{clk: clk_out, tick: tick, cur: div_cur, rdy: div_ready};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL div2 cyc %0d: got clk=%b tick=%b cur=%0d rdy=%b want clk=%b tick=%b cur=%0d rdy=%b",
                 i, got.clk, got.tick, got.cur, got.rdy, e.clk, e.tick, e.cur, e.rdy);
      end
    end
  endtask

  task automatic test_load_odd();
    push_one(1'b0, 1'b0, 2, 1'b0);
    repeat (2) push_range(5, 0, 4, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) begin div_in = 8'd5; div_valid = 1'b1; end
      if (i == 1) div_valid = 1'b0;
      cyc();
      got = '{clk: clk_out, tick: tick, cur: div_cur, rdy: div_ready};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL load_odd cyc %0d: got clk=%b tick=%b cur=%0d rdy=%b want clk=%b tick=%b cur=%0d rdy=%b",
                 i, got.clk, got.tick, got.cur, got.rdy, e.clk, e.tick, e.cur, e.rdy);
      end
    end
  endtask

  task automatic test_bypass();
    push_range(5, 0, 4, 1'b0);
    repeat (4) push_range(1, 0, 0, 1'b1);
    push_range(1, 0, 0, 1'b0);
    repeat (2) push_range(4, 0, 3, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) begin div_in = 8'd1; div_valid = 1'b1; end
      if (i == 1) div_valid = 1'b0;
      if (i == 9) begin div_in = 8'd4; div_valid = 1'b1; end
      if (i == 10) div_valid = 1'b0;
      cyc();
      got = '{clk: clk_out, tick: tick, cur: div_cur, rdy: div_ready};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL bypass cyc %0d: got clk=%b tick=%b cur=%0d rdy=%b want clk=%b tick=%b cur=%0d rdy=%b",
                 i, got.clk, got.tick, got.cur, got.rdy, e.clk, e.tick, e.cur, e.rdy);
      end
      if (i == 6) begin
        // In bypass clk_out must follow clk_in low as well.
        @(negedge clk_in);
        #1;
        total++;
        if (clk_out !== 1'b0) begin
          bad++;
          $display("FAIL bypass_low: got clk_out=%b want 0", clk_out);
        end
      end
    end
  endtask

  task automatic test_en_freeze();
    push_range(4, 0, 0, 1'b1);
    push_one(1'b1, 1'b0, 4, 1'b0);
    repeat (7) push_one(1'b1, 1'b0, 4, 1'b0);
    push_range(4, 2, 3, 1'b0);
    repeat (2) push_range(3, 0, 2, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 1) begin div_in = 8'd3; div_valid = 1'b1; end
      if (i == 2) begin div_valid = 1'b0; en = 1'b0; end
      if (i == 9) en = 1'b1;
      cyc();
      got = '{clk: clk_out, tick: tick, cur: div_cur, rdy: div_ready};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL en_freeze cyc %0d: got clk=%b tick=%b cur=%0d rdy=%b want clk=%b tick=%b cur=%0d rdy=%b",
                 i, got.clk, got.tick, got.cur, got.rdy, e.clk, e.tick, e.cur, e.rdy);
      end
    end
  endtask

  task automatic test_clamp_max();
    push_range(3, 0, 2, 1'b0);
    repeat (2) push_range(1, 0, 0, 1'b1);
    push_range(1, 0, 0, 1'b0);
    // Previous clk level was high (bypass), so the first period starts high in both builds.
    push_one(1'b1, 1'b1, 255, 1'b1);
    push_range(255, 1, 254, 1'b1);
    push_range(255, 0, 0, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) begin div_in = 8'd0; div_valid = 1'b1; end
      if (i == 1) div_valid = 1'b0;
      if (i == 5) begin div_in = 8'd255; div_valid = 1'b1; end
      if (i == 6) div_valid = 1'b0;
      cyc();
      got = '{clk: clk_out, tick: tick, cur: div_cur, rdy: div_ready};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL clamp_max cyc %0d: got clk=%b tick=%b cur=%0d rdy=%b want clk=%b tick=%b cur=%0d rdy=%b",
                 i, got.clk, got.tick, got.cur, got.rdy, e.clk, e.tick, e.cur, e.rdy);
      end
    end
  endtask

  task automatic test_reset_pending();
    push_one(1'b1, 1'b0, 255, 1'b0);
    push_one(1'b1, 1'b0, 2, 1'b1);
    push_range(2, 1, 1, 1'b1);
    repeat (3) push_range(2, 0, 1, 1'b1);
    for (int i = 0; sb.size() > 0; i++) begin
      if (i == 0) begin div_in = 8'd7; div_valid = 1'b1; end
      if (i == 1) begin div_valid = 1'b0; rst_n = 1'b0; end
      if (i == 2) rst_n = 1'b1;
      cyc();
      got = '{clk: clk_out, tick: tick, cur: div_cur, rdy: div_ready};
      e = sb.pop_front();
      total++;
      if (got !== e) begin
        bad++;
        $display("FAIL reset_pending cyc %0d: got clk=%b tick=%b cur=%0d rdy=%b want clk=%b tick=%b cur=%0d rdy=%b",
                 i, got.clk, got.tick, got.cur, got.rdy, e.clk, e.tick, e.cur, e.rdy);
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    en        = 1'b1;
    div_valid = 1'b0;
    div_in    = 8'd0;
    test_reset();
    test_div2();
    test_load_odd();
    test_bypass();
    test_en_freeze();
    test_clamp_max();
    test_reset_pending();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
